// File: rtl/stc1_pkg.sv
// Shared types and defaults for the stc1 pad-ring stream bridge.
package stc1_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } egress_state_e;

  localparam int PAD_W_DEF  = 8;
  localparam int WORD_W_DEF = 32;
  localparam int DEPTH_DEF  = 8;

  function automatic int stc1_beats(input int word_w, input int pad_w);
    return word_w / pad_w;
  endfunction

endpackage

// File: rtl/stc1_sync_fifo.sv
// Single-clock word FIFO; pointers carry one extra wrap bit so full/empty/level fall out of the difference.
module stc1_sync_fifo
  import stc1_pkg::*;
#(
  parameter int WIDTH = WORD_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = LVL_W'(wr_ptr - rd_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_ok = wr_en && (!full || rd_en);
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/stc1_stream_bridge.sv
// Pad-width ingress assembly into words, FIFO buffering, and half-rate re-serialised egress.
// Optional egress parity is built when STC1_EGRESS_PARITY_EN is defined.
module stc1_stream_bridge
  import stc1_pkg::*;
#(
  parameter int PAD_W  = PAD_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                         ClkIngress,
  input  logic                         ARst,
  input  logic [PAD_W-1:0]             ID,
  input  logic                         IValid,
  input  logic                         ISof,
  output logic [PAD_W-1:0]             ED,
  output logic                         EValid,
  output logic                         EClk,
  input  logic                         EStall,
  output logic                         EPar,
  output logic                         Overflow,
  output logic [$clog2(DEPTH+1)-1:0]   Level
);

  localparam int BEATS = stc1_beats(WORD_W, PAD_W);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  slot;
  logic [WORD_W-1:0] asm_word;
  logic [WORD_W-1:0] asm_next;
  logic              word_done;

  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_rd_data;

  egress_state_e     state, state_nxt;
  logic              eclk_q;
  logic [CNT_W-1:0]  rem, rem_nxt;
  logic [WORD_W-1:0] shreg, sh_nxt;
  logic [PAD_W-1:0]  ed_p1, ed_nxt;
  logic              vld_p1, vld_nxt;
  logic              overflow_q;

  // Ingress: a start-of-word beat always lands in slot 0, discarding any partial word.
  always_comb begin
    slot      = ISof ? '0 : beat_cnt;
    asm_next  = asm_word;
    asm_next[int'(slot)*PAD_W +: PAD_W] = ID;
    word_done = IValid && (int'(slot) == BEATS - 1);
  end

  always_ff @(posedge ClkIngress or posedge ARst) begin
    if (ARst) beat_cnt <= '0;
    else if (IValid) beat_cnt <= word_done ? '0 : slot + 1'b1;
  end

  always_ff @(posedge ClkIngress) begin
    if (IValid) asm_word <= asm_next;
  end

  stc1_sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (ClkIngress),
    .rst     (ARst),
    .wr_en   (word_done),
    .wr_data (asm_next),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (Level)
  );

  // Egress: decisions are taken only on the edge that enters EClk-low (beat boundary).
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    rem_nxt   = rem;
    sh_nxt    = shreg;
    ed_nxt    = ed_p1;
    vld_nxt   = vld_p1;
    if (eclk_q) begin
      vld_nxt = 1'b0;
      if (state == IDLE || rem == '0) begin
        if (!fifo_empty && !EStall) begin
          pop       = 1'b1;
          ed_nxt    = fifo_rd_data[PAD_W-1:0];
          sh_nxt    = fifo_rd_data >> PAD_W;
          rem_nxt   = CNT_W'(BEATS - 1);
          vld_nxt   = 1'b1;
          state_nxt = SEND;
        end else begin
          state_nxt = IDLE;
        end
      end else if (!EStall) begin
        ed_nxt  = shreg[PAD_W-1:0];
        sh_nxt  = shreg >> PAD_W;
        rem_nxt = rem - 1'b1;
        vld_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge ClkIngress or posedge ARst) begin
    if (ARst) begin
      state      <= IDLE;
      eclk_q     <= 1'b0;
      rem        <= '0;
      ed_p1      <= '0;
      vld_p1     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      eclk_q <= ~eclk_q;
      rem    <= rem_nxt;
      ed_p1  <= ed_nxt;
      vld_p1 <= vld_nxt;
      if (word_done && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge ClkIngress) begin
    shreg <= sh_nxt;
  end

`ifdef STC1_EGRESS_PARITY_EN
  logic epar_p1;

  always_ff @(posedge ClkIngress or posedge ARst) begin
    if (ARst) epar_p1 <= 1'b0;
    else      epar_p1 <= ^ed_nxt;
  end

  assign EPar = epar_p1;
`else
  assign EPar = 1'b0;
`endif

  assign ED       = ed_p1;
  assign EValid   = vld_p1;
  assign EClk     = eclk_q;
  assign Overflow = overflow_q;

endmodule
